// File: rtl/retirement_packer_pkg.sv
// Shared widths, itype encodings and record/group field layouts for the
// retirement packer.
package retirement_packer_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ILASTSIZE_LEN = 1;
  localparam int unsigned ITYPE_LEN     = 3;
  localparam int unsigned CAUSE_LEN     = 5;
  localparam int unsigned PRIV_LEN      = 2;

  localparam logic [ITYPE_LEN-1:0] ITYPE_NONE = 3'd0;
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC  = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT  = 3'd2;

  typedef enum logic {
    ST_FILL,
    ST_PENDING
  } state_e;

  typedef struct packed {
    logic                     iretire;
    logic [ILASTSIZE_LEN-1:0] ilastsize;
    logic [ITYPE_LEN-1:0]     itype;
    logic [XLEN-1:0]          iaddr;
  } lane_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } group_common_s;

  function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
    return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
  endfunction

endpackage

// File: rtl/retirement_packer_idle_ctr.sv
// Saturating up-counter measuring idle cycles of a partially filled group.
module retirement_packer_idle_ctr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/retirement_packer.sv
// Repacks a single-lane retirement stream into NrRetiredInstr-wide groups
// sharing one cause/tval/priv. Fill buffer feeds a registered output stage.
//
// state      | meaning
// ST_FILL    | accepting records into the fill buffer
// ST_PENDING | fill buffer holds a closed group waiting for the output register
module retirement_packer
  import retirement_packer_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned Timeout        = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          valid_i,
  output logic                                          ready_o,
  input  logic                                          iretire_i,
  input  logic [ILASTSIZE_LEN-1:0]                      ilastsize_i,
  input  logic [ITYPE_LEN-1:0]                          itype_i,
  input  logic [CAUSE_LEN-1:0]                          cause_i,
  input  logic [XLEN-1:0]                               tval_i,
  input  logic [PRIV_LEN-1:0]                           priv_i,
  input  logic [XLEN-1:0]                               iaddr_i,
  input  logic                                          flush_i,
  output logic                                          valid_o,
  input  logic                                          ready_i,
  output logic [NrRetiredInstr-1:0][0:0]                iretire_o,
  output logic [NrRetiredInstr-1:0][ILASTSIZE_LEN-1:0]  ilastsize_o,
  output logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]      itype_o,
  output logic [NrRetiredInstr-1:0][XLEN-1:0]           iaddr_o,
  output logic [CAUSE_LEN-1:0]                          cause_o,
  output logic [XLEN-1:0]                               tval_o,
  output logic [PRIV_LEN-1:0]                           priv_o
);

  localparam int unsigned CntW  = $clog2(NrRetiredInstr + 1);
  localparam int unsigned IdleW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;

  state_e                           state_q, state_d;
  lane_s         [NrRetiredInstr-1:0] buf_q, buf_d, out_q, out_d, grp;
  group_common_s                    bcom_q, bcom_d, ocom_q, ocom_d, gcom;
  logic          [CntW-1:0]         cnt_q, cnt_d, new_cnt;
  logic                             valid_q, valid_d;
  logic          [IdleW-1:0]        idle_q;

  logic out_free, has_grp, hold_close, fill_close, accept, keep;

  always_comb begin
    out_free   = !valid_q || ready_i;
    has_grp    = (cnt_q != '0);
    // flush, priv change and timeout close the group without taking the record
    hold_close = has_grp && (flush_i || (valid_i && (priv_i != bcom_q.priv)) ||
                 ((Timeout != 0) && (idle_q == IdleW'(Timeout))));
    ready_o    = (state_q == ST_FILL) && !hold_close;
    accept     = valid_i && ready_o;
    keep       = accept && !(!iretire_i && (itype_i == ITYPE_NONE));

    grp     = buf_q;
    gcom    = bcom_q;
    new_cnt = cnt_q;
    if (keep) begin
      for (int i = 0; i < NrRetiredInstr; i++) begin
        if (cnt_q == CntW'(i)) grp[i] = '{iretire_i, ilastsize_i, itype_i, iaddr_i};
      end
      gcom.cause = cause_i;
      gcom.tval  = tval_i;
      if (!has_grp) gcom.priv = priv_i;
      new_cnt = cnt_q + 1'b1;
    end
    fill_close = keep && ((new_cnt == CntW'(NrRetiredInstr)) || is_trap(itype_i));

    state_d = state_q;
    buf_d   = buf_q;
    bcom_d  = bcom_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ocom_d  = ocom_q;
    valid_d = valid_q && !ready_i;

    unique case (state_q)
      ST_FILL: begin
        if (hold_close || fill_close) begin
          if (out_free) begin
            out_d   = hold_close ? buf_q : grp;
            ocom_d  = hold_close ? bcom_q : gcom;
            valid_d = 1'b1;
            buf_d   = '0;
            bcom_d  = '0;
            cnt_d   = '0;
          end else begin
            buf_d   = hold_close ? buf_q : grp;
            bcom_d  = hold_close ? bcom_q : gcom;
            cnt_d   = hold_close ? cnt_q : new_cnt;
            state_d = ST_PENDING;
          end
        end else begin
          buf_d  = grp;
          bcom_d = gcom;
          cnt_d  = new_cnt;
        end
      end
      ST_PENDING: begin
        if (out_free) begin
          out_d   = buf_q;
          ocom_d  = bcom_q;
          valid_d = 1'b1;
          buf_d   = '0;
          bcom_d  = '0;
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  retirement_packer_idle_ctr #(
    .WIDTH(IdleW)
  ) i_idle_ctr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (keep || hold_close || fill_close || (state_q == ST_PENDING)),
    .en_i  (has_grp),
    .cnt_o (idle_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FILL;
      buf_q   <= '0;
      bcom_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ocom_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      bcom_q  <= bcom_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ocom_q  <= ocom_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NrRetiredInstr; i++) begin
      iretire_o[i]   = out_q[i].iretire;
      ilastsize_o[i] = out_q[i].ilastsize;
      itype_o[i]     = out_q[i].itype;
      iaddr_o[i]     = out_q[i].iaddr;
    end
  end

  assign valid_o = valid_q;
  assign cause_o = ocom_q.cause;
  assign tval_o  = ocom_q.tval;
  assign priv_o  = ocom_q.priv;

endmodule

// File: tb/tb_retirement_packer.sv
// Directed bench for retirement_packer with NrRetiredInstr=2, Timeout=4.
module tb_retirement_packer;
  import retirement_packer_pkg::*;

  logic                           clk_i = 1'b0;
  logic                           rst_ni;
  logic                           valid_i, ready_o, iretire_i, flush_i, valid_o, ready_i;
  logic [ILASTSIZE_LEN-1:0]       ilastsize_i;
  logic [ITYPE_LEN-1:0]           itype_i;
  logic [CAUSE_LEN-1:0]           cause_i, cause_o;
  logic [XLEN-1:0]                tval_i, iaddr_i, tval_o;
  logic [PRIV_LEN-1:0]            priv_i, priv_o;
  logic [1:0][0:0]                iretire_o;
  logic [1:0][ILASTSIZE_LEN-1:0]  ilastsize_o;
  logic [1:0][ITYPE_LEN-1:0]      itype_o;
  logic [1:0][XLEN-1:0]           iaddr_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  retirement_packer #(.NrRetiredInstr(2), .Timeout(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
    .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .iaddr_i(iaddr_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
    .iaddr_o(iaddr_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [XLEN-1:0] addr, input logic [ITYPE_LEN-1:0] it,
                       input logic [PRIV_LEN-1:0] pv, input logic [CAUSE_LEN-1:0] cs,
                       input logic [XLEN-1:0] tv);
    valid_i = 1'b1; iretire_i = 1'b1; ilastsize_i = 1'b1; itype_i = it;
    priv_i = pv; cause_i = cs; tval_i = tv; iaddr_i = addr;
  endtask

  task automatic idle_in();
    valid_i = 1'b0; iretire_i = 1'b0; itype_i = ITYPE_NONE; iaddr_i = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ready_i = 1'b1; flush_i = 1'b0; ilastsize_i = '0;
    cause_i = '0; tval_i = '0; priv_i = '0; idle_in();
    #12;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if ({iaddr_o, iretire_o, cause_o, tval_o, priv_o} !== '0) begin failures++; $display("FAIL reset_outputs got %h want 0", {iaddr_o, cause_o, tval_o, priv_o}); end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", ready_o); end
  endtask

  task automatic test_full_groups();
    logic [XLEN-1:0] addrs [4];
    addrs = '{32'h100, 32'h104, 32'h108, 32'h10C};
    ready_i = 1'b1;
    for (int g = 0; g < 2; g++) begin
      drive(addrs[2*g], ITYPE_NONE, 2'd3, 5'd0, 32'h0);
      @(negedge clk_i);
      checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL full_ready0 got %b want 1", ready_o); end
      tick();
      drive(addrs[2*g+1], ITYPE_NONE, 2'd3, 5'd0, 32'h0);
      @(negedge clk_i);
      checks++; if ({valid_o, ready_o} !== 2'b01) begin failures++; $display("FAIL full_mid got v/r %b want 01", {valid_o, ready_o}); end
      tick();
      idle_in();
      @(negedge clk_i);
      checks++; if (valid_o !== 1'b1 || iretire_o !== 2'b11 || iaddr_o[0] !== addrs[2*g] || iaddr_o[1] !== addrs[2*g+1])
        begin failures++; $display("FAIL full_group%0d got v=%b ret=%b a0=%h a1=%h want 1 11 %h %h", g, valid_o, iretire_o, iaddr_o[0], iaddr_o[1], addrs[2*g], addrs[2*g+1]); end
      checks++; if (priv_o !== 2'd3) begin failures++; $display("FAIL full_priv got %0d want 3", priv_o); end
      tick();
    end
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL full_drained got %b want 0", valid_o); end
    tick();
  endtask

  task automatic test_exception();
    drive(32'h200, ITYPE_EXC, 2'd3, 5'd2, 32'hDEAD);
    tick();
    idle_in();
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b1 || iretire_o !== 2'b01 || iaddr_o[0] !== 32'h200 || iaddr_o[1] !== 32'h0)
      begin failures++; $display("FAIL exc_group got v=%b ret=%b a0=%h a1=%h want 1 01 200 0", valid_o, iretire_o, iaddr_o[0], iaddr_o[1]); end
    checks++; if (cause_o !== 5'd2 || tval_o !== 32'hDEAD || itype_o[0] !== ITYPE_EXC || itype_o[1] !== ITYPE_NONE || ilastsize_o[1] !== 1'b0)
      begin failures++; $display("FAIL exc_fields got cause=%0d tval=%h it0=%0d it1=%0d want 2 dead 1 0", cause_o, tval_o, itype_o[0], itype_o[1]); end
    tick();
  endtask

  task automatic test_priv_change();
    drive(32'h300, ITYPE_NONE, 2'd3, 5'd0, 32'h0);
    tick();
    drive(32'h304, ITYPE_NONE, 2'd1, 5'd0, 32'h0);
    @(negedge clk_i);
    checks++; if ({ready_o, valid_o} !== 2'b00) begin failures++; $display("FAIL priv_bubble got r/v %b want 00", {ready_o, valid_o}); end
    tick();
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b1 || iretire_o !== 2'b01 || iaddr_o[0] !== 32'h300 || priv_o !== 2'd3 || ready_o !== 1'b1)
      begin failures++; $display("FAIL priv_group1 got v=%b ret=%b a0=%h priv=%0d r=%b want 1 01 300 3 1", valid_o, iretire_o, iaddr_o[0], priv_o, ready_o); end
    tick();
    idle_in();
    flush_i = 1'b1;
    @(negedge clk_i);
    checks++; if ({ready_o, valid_o} !== 2'b00) begin failures++; $display("FAIL flush_ready got r/v %b want 00", {ready_o, valid_o}); end
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b1 || iretire_o !== 2'b01 || iaddr_o[0] !== 32'h304 || priv_o !== 2'd1)
      begin failures++; $display("FAIL priv_group2 got v=%b ret=%b a0=%h priv=%0d want 1 01 304 1", valid_o, iretire_o, iaddr_o[0], priv_o); end
    tick();
  endtask

  task automatic test_flush_empty();
    flush_i = 1'b1;
    @(negedge clk_i);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL flush_empty_ready got %b want 1", ready_o); end
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL flush_empty_valid got %b want 0", valid_o); end
  endtask

  task automatic test_timeout();
    drive(32'h400, ITYPE_NONE, 2'd0, 5'd0, 32'h0);
    tick();
    idle_in();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL timeout_early cycle %0d got %b want 0", k, valid_o); end
      tick();
    end
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b1 || iretire_o !== 2'b01 || iaddr_o[0] !== 32'h400 || iaddr_o[1] !== 32'h0)
      begin failures++; $display("FAIL timeout_group got v=%b ret=%b a0=%h a1=%h want 1 01 400 0", valid_o, iretire_o, iaddr_o[0], iaddr_o[1]); end
    tick();
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b0;
    drive(32'h500, ITYPE_NONE, 2'd3, 5'd0, 32'h0); tick();
    drive(32'h504, ITYPE_NONE, 2'd3, 5'd0, 32'h0); tick();
    drive(32'h508, ITYPE_NONE, 2'd3, 5'd0, 32'h0);
    @(negedge clk_i);
    checks++; if ({valid_o, ready_o} !== 2'b11) begin failures++; $display("FAIL bp_fill2 got v/r %b want 11", {valid_o, ready_o}); end
    tick();
    drive(32'h50C, ITYPE_NONE, 2'd3, 5'd0, 32'h0); tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1 || iaddr_o[0] !== 32'h500 || iaddr_o[1] !== 32'h504)
        begin failures++; $display("FAIL bp_hold%0d got r=%b v=%b a0=%h a1=%h want 0 1 500 504", k, ready_o, valid_o, iaddr_o[0], iaddr_o[1]); end
      tick();
    end
    ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b1 || iaddr_o[0] !== 32'h508 || iaddr_o[1] !== 32'h50C || iretire_o !== 2'b11 || ready_o !== 1'b1)
      begin failures++; $display("FAIL bp_group2 got v=%b a0=%h a1=%h ret=%b r=%b want 1 508 50c 11 1", valid_o, iaddr_o[0], iaddr_o[1], iretire_o, ready_o); end
    tick();
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_drained got %b want 0", valid_o); end
    tick();
  endtask

  task automatic test_reset_mid_group();
    drive(32'h600, ITYPE_NONE, 2'd3, 5'd0, 32'h0); tick();
    idle_in();
    rst_ni = 1'b0;
    #3;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got %b want 0", valid_o); end
    tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_i);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_ghost cycle %0d got %b want 0", k, valid_o); end
      tick();
    end
    drive(32'h608, ITYPE_NONE, 2'd2, 5'd0, 32'h0); tick();
    drive(32'h60C, ITYPE_NONE, 2'd2, 5'd0, 32'h0); tick();
    idle_in();
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b1 || iaddr_o[0] !== 32'h608 || iaddr_o[1] !== 32'h60C || priv_o !== 2'd2)
      begin failures++; $display("FAIL rst_mid_group got v=%b a0=%h a1=%h priv=%0d want 1 608 60c 2", valid_o, iaddr_o[0], iaddr_o[1], priv_o); end
    tick();
  endtask

  initial begin
    test_reset();
    tick();
    test_full_groups();
    test_exception();
    test_priv_change();
    test_flush_empty();
    test_timeout();
    test_back_to_back();
    test_reset_mid_group();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
